// File: rtl/bht_predictor_pkg.sv
// rtl/bht_predictor_pkg.sv - shared opcodes, FSM states and default parameters
package bht_predictor_pkg;

  localparam int DEF_INDEX_W  = 6;
  localparam int DEF_CTR_W    = 2;
  localparam int DEF_TAG_W    = 8;
  localparam int DEF_CTR_INIT = 1;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_JALR = 1'b1
  } state_e;

endpackage

// File: rtl/bht_predictor_sat_counter_table.sv
// rtl/bht_predictor_sat_counter_table.sv - saturating counter table, one read port, one update port
module sat_counter_table
  import bht_predictor_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int CTR_INIT = DEF_CTR_INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [CTR_W-1:0]   rd_ctr,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               upd_taken
);

  localparam int                 N        = 1 << INDEX_W;
  localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]   CTR_RST  = CTR_W'(CTR_INIT);

  logic [CTR_W-1:0] ctr_q [N];
  logic [CTR_W-1:0] ctr_d [N];
  logic [CTR_W-1:0] cur;

  // Read from the registered array so a same-cycle update is not visible.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    cur   = ctr_q[upd_idx];
    if (upd_valid) begin
      if (upd_taken && (cur != CTR_MAX)) begin
        ctr_d[upd_idx] = cur + CTR_W'(1);
      end else if (!upd_taken && (cur != '0)) begin
        ctr_d[upd_idx] = cur - CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (en) begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - branch predictor: BHT counters, JALR BTB and immediate decode
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int CTR_INIT = DEF_CTR_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_instr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_is_jump,
  output logic        resp_taken,
  output logic [31:0] resp_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jalr,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        alu_jalr_valid,
  input  logic [31:0] alu_jalr_target,
  input  logic        flush
);

  localparam int N = 1 << INDEX_W;

  state_e      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_is_jump_q, resp_is_jump_d;
  logic        resp_taken_q, resp_taken_d;
  logic [31:0] resp_pc_q, resp_pc_d;

  logic             btb_valid_q  [N];
  logic             btb_valid_d  [N];
  logic [TAG_W-1:0] btb_tag_q    [N];
  logic [TAG_W-1:0] btb_tag_d    [N];
  logic [31:0]      btb_target_q [N];
  logic [31:0]      btb_target_d [N];

  logic [INDEX_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0]   req_tag, upd_tag;
  logic [CTR_W-1:0]   rd_ctr;
  logic [6:0]         opcode;
  logic [31:0]        imm_j, imm_b, pc_plus4;
  logic               btb_hit, br_taken;

  assign req_idx  = req_pc[INDEX_W+1:2];
  assign req_tag  = req_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign upd_idx  = upd_pc[INDEX_W+1:2];
  assign upd_tag  = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  assign opcode   = req_instr[6:0];
  assign imm_j    = {{12{req_instr[31]}}, req_instr[19:12], req_instr[20], req_instr[30:21], 1'b0};
  assign imm_b    = {{20{req_instr[31]}}, req_instr[7], req_instr[30:25], req_instr[11:8], 1'b0};
  assign pc_plus4 = req_pc + 32'd4;
  assign btb_hit  = btb_valid_q[req_idx] && (btb_tag_q[req_idx] == req_tag);
  assign br_taken = rd_ctr[CTR_W-1];

  sat_counter_table #(
    .INDEX_W  (INDEX_W),
    .CTR_W    (CTR_W),
    .CTR_INIT (CTR_INIT)
  ) u_ctr_table (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .rd_idx    (req_idx),
    .rd_ctr    (rd_ctr),
    .upd_valid (upd_valid && !upd_is_jalr),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken)
  );

  always_comb begin
    state_d        = state_q;
    resp_valid_d   = 1'b0;
    resp_is_jump_d = resp_is_jump_q;
    resp_taken_d   = resp_taken_q;
    resp_pc_d      = resp_pc_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            case (opcode)
              OPC_JAL: begin
                resp_valid_d   = 1'b1;
                resp_is_jump_d = 1'b1;
                resp_taken_d   = 1'b1;
                resp_pc_d      = req_pc + imm_j;
              end
              OPC_BRANCH: begin
                resp_valid_d   = 1'b1;
                resp_is_jump_d = 1'b1;
                resp_taken_d   = br_taken;
                resp_pc_d      = br_taken ? (req_pc + imm_b) : pc_plus4;
              end
              OPC_JALR: begin
                if (btb_hit) begin
                  resp_valid_d   = 1'b1;
                  resp_is_jump_d = 1'b1;
                  resp_taken_d   = 1'b1;
                  resp_pc_d      = btb_target_q[req_idx];
                end else begin
                  state_d = ST_WAIT_JALR;
                end
              end
              default: begin
                resp_valid_d   = 1'b1;
                resp_is_jump_d = 1'b0;
                resp_taken_d   = 1'b0;
                resp_pc_d      = pc_plus4;
              end
            endcase
          end
        end
        ST_WAIT_JALR: begin
          if (alu_jalr_valid) begin
            resp_valid_d   = 1'b1;
            resp_is_jump_d = 1'b1;
            resp_taken_d   = 1'b1;
            resp_pc_d      = alu_jalr_target;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid && upd_is_jalr) begin
      btb_valid_d[upd_idx]  = 1'b1;
      btb_tag_d[upd_idx]    = upd_tag;
      btb_target_d[upd_idx] = upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      resp_valid_q   <= 1'b0;
      resp_is_jump_q <= 1'b0;
      resp_taken_q   <= 1'b0;
      resp_pc_q      <= 32'd0;
      for (int i = 0; i < N; i++) begin
        btb_valid_q[i] <= 1'b0;
      end
    end else if (rdy) begin
      state_q        <= state_d;
      resp_valid_q   <= resp_valid_d;
      resp_is_jump_q <= resp_is_jump_d;
      resp_taken_q   <= resp_taken_d;
      resp_pc_q      <= resp_pc_d;
      btb_valid_q    <= btb_valid_d;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset value.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_is_jump = resp_is_jump_q;
  assign resp_taken   = resp_taken_q;
  assign resp_pc      = resp_pc_q;

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - directed self-checking bench for bht_predictor
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        req_valid;
  logic [31:0] req_pc, req_instr;
  logic        req_ready;
  logic        resp_valid, resp_is_jump, resp_taken;
  logic [31:0] resp_pc;
  logic        upd_valid, upd_is_jalr, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic        alu_jalr_valid;
  logic [31:0] alu_jalr_target;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] INSTR_JALR = 32'h0000_0067;

  bht_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .req_instr       (req_instr),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_is_jump    (resp_is_jump),
    .resp_taken      (resp_taken),
    .resp_pc         (resp_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jalr     (upd_is_jalr),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .alu_jalr_valid  (alu_jalr_valid),
    .alu_jalr_target (alu_jalr_target),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic is_jalr, input logic taken,
                        input logic [31:0] target);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_is_jalr = is_jalr;
    upd_taken   = taken;
    upd_target  = target;
    cycle();
    upd_valid   = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] instr);
    req_valid = 1'b1;
    req_pc    = pc;
    req_instr = instr;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b0;
    cycle();
    cycle();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_is_jump !== 1'b0) begin n_fail++; $display("FAIL reset_is_jump: got %b expected 0", resp_is_jump); end
    n_checks++; if (resp_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", resp_taken); end
    n_checks++; if (resp_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", resp_pc); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    rst = 1'b1;
    rdy = 1'b1;
    cycle();
  endtask

  task automatic test_jal();
    lookup(32'h100, enc_jal(21'h20));
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL jal_valid: got %b expected 1", resp_valid); end
    n_checks++; if (resp_is_jump !== 1'b1) begin n_fail++; $display("FAIL jal_is_jump: got %b expected 1", resp_is_jump); end
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL jal_taken: got %b expected 1", resp_taken); end
    n_checks++; if (resp_pc !== 32'h120) begin n_fail++; $display("FAIL jal_pc: got %h expected 120", resp_pc); end
    cycle();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL jal_one_cycle: got %b expected 0", resp_valid); end
  endtask

  task automatic test_branch();
    lookup(32'h200, enc_br(13'h1FF8));
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL br_nt_valid: got %b expected 1", resp_valid); end
    n_checks++; if (resp_is_jump !== 1'b1) begin n_fail++; $display("FAIL br_nt_is_jump: got %b expected 1", resp_is_jump); end
    n_checks++; if (resp_taken !== 1'b0) begin n_fail++; $display("FAIL br_nt_taken: got %b expected 0", resp_taken); end
    n_checks++; if (resp_pc !== 32'h204) begin n_fail++; $display("FAIL br_nt_pc: got %h expected 204", resp_pc); end
    do_upd(32'h200, 1'b0, 1'b1, 32'h0);
    do_upd(32'h200, 1'b0, 1'b1, 32'h0);
    lookup(32'h200, enc_br(13'h1FF8));
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL br_t_taken: got %b expected 1", resp_taken); end
    n_checks++; if (resp_pc !== 32'h1F8) begin n_fail++; $display("FAIL br_t_pc: got %h expected 1f8", resp_pc); end
    cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) do_upd(32'h240, 1'b0, 1'b0, 32'h0);
    do_upd(32'h240, 1'b0, 1'b1, 32'h0);
    lookup(32'h240, enc_br(13'h0010));
    n_checks++; if (resp_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_taken: got %b expected 0", resp_taken); end
    n_checks++; if (resp_pc !== 32'h244) begin n_fail++; $display("FAIL sat_low_pc: got %h expected 244", resp_pc); end
    for (int i = 0; i < 4; i++) do_upd(32'h240, 1'b0, 1'b1, 32'h0);
    lookup(32'h240, enc_br(13'h0010));
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL sat_high_taken: got %b expected 1", resp_taken); end
    do_upd(32'h240, 1'b0, 1'b0, 32'h0);
    lookup(32'h240, enc_br(13'h0010));
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL sat_high_dec_taken: got %b expected 1", resp_taken); end
    n_checks++; if (resp_pc !== 32'h250) begin n_fail++; $display("FAIL sat_high_dec_pc: got %h expected 250", resp_pc); end
    cycle();
  endtask

  task automatic test_read_before_write();
    do_upd(32'h280, 1'b0, 1'b1, 32'h0);
    upd_valid   = 1'b1;
    upd_pc      = 32'h280;
    upd_is_jalr = 1'b0;
    upd_taken   = 1'b0;
    lookup(32'h280, enc_br(13'h0010));
    upd_valid = 1'b0;
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL rbw_taken: got %b expected 1", resp_taken); end
    n_checks++; if (resp_pc !== 32'h290) begin n_fail++; $display("FAIL rbw_pc: got %h expected 290", resp_pc); end
    lookup(32'h280, enc_br(13'h0010));
    n_checks++; if (resp_taken !== 1'b0) begin n_fail++; $display("FAIL rbw_after_taken: got %b expected 0", resp_taken); end
    n_checks++; if (resp_pc !== 32'h284) begin n_fail++; $display("FAIL rbw_after_pc: got %h expected 284", resp_pc); end
    cycle();
  endtask

  task automatic test_rdy_hold();
    rdy = 1'b0;
    upd_valid   = 1'b1;
    upd_pc      = 32'h280;
    upd_is_jalr = 1'b0;
    upd_taken   = 1'b1;
    lookup(32'h100, enc_jal(21'h20));
    upd_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_hold_valid: got %b expected 0", resp_valid); end
    rdy = 1'b1;
    lookup(32'h280, enc_br(13'h0010));
    n_checks++; if (resp_taken !== 1'b0) begin n_fail++; $display("FAIL rdy_hold_ctr: got %b expected 0", resp_taken); end
    cycle();
  endtask

  task automatic test_jalr_miss();
    alu_jalr_valid  = 1'b1;
    alu_jalr_target = 32'h999;
    cycle();
    alu_jalr_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_alu_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_alu_ready: got %b expected 1", req_ready); end
    lookup(32'h300, INSTR_JALR);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL miss_ready: got %b expected 0", req_ready); end
    cycle();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL miss_stall: got %b expected 0", req_ready); end
    alu_jalr_valid  = 1'b1;
    alu_jalr_target = 32'h480;
    cycle();
    alu_jalr_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL resolve_valid: got %b expected 1", resp_valid); end
    n_checks++; if (resp_is_jump !== 1'b1) begin n_fail++; $display("FAIL resolve_is_jump: got %b expected 1", resp_is_jump); end
    n_checks++; if (resp_taken !== 1'b1) begin n_fail++; $display("FAIL resolve_taken: got %b expected 1", resp_taken); end
    n_checks++; if (resp_pc !== 32'h480) begin n_fail++; $display("FAIL resolve_pc: got %h expected 480", resp_pc); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL resolve_ready: got %b expected 1", req_ready); end
    cycle();
  endtask

  task automatic test_jalr_hit();
    do_upd(32'h300, 1'b1, 1'b1, 32'h480);
    lookup(32'h300, INSTR_JALR);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b expected 1", resp_valid); end
    n_checks++; if (resp_pc !== 32'h480) begin n_fail++; $display("FAIL hit_pc: got %h expected 480", resp_pc); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hit_ready: got %b expected 1", req_ready); end
    cycle();
  endtask

  task automatic test_flush();
    lookup(32'h400, INSTR_JALR);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL tag_miss_ready: got %b expected 0", req_ready); end
    flush           = 1'b1;
    alu_jalr_valid  = 1'b1;
    alu_jalr_target = 32'h480;
    cycle();
    alu_jalr_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_alu_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_alu_ready: got %b expected 1", req_ready); end
    lookup(32'h100, enc_jal(21'h20));
    flush = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_valid: got %b expected 0", resp_valid); end
    cycle();
  endtask

  task automatic test_reset_in_wait();
    lookup(32'h500, INSTR_JALR);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rw_pre_ready: got %b expected 0", req_ready); end
    rst             = 1'b0;
    rdy             = 1'b0;
    alu_jalr_valid  = 1'b1;
    alu_jalr_target = 32'h480;
    cycle();
    alu_jalr_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_pc !== 32'h0) begin n_fail++; $display("FAIL rw_pc: got %h expected 0", resp_pc); end
    rst = 1'b1;
    rdy = 1'b1;
    lookup(32'h300, INSTR_JALR);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rw_btb_cleared: got %b expected 0", req_ready); end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_flush_ready: got %b expected 1", req_ready); end
  endtask

  initial begin
    rst             = 1'b0;
    rdy             = 1'b0;
    req_valid       = 1'b0;
    req_pc          = 32'h0;
    req_instr       = 32'h0;
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
    upd_is_jalr     = 1'b0;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    alu_jalr_valid  = 1'b0;
    alu_jalr_target = 32'h0;
    flush           = 1'b0;

    test_reset();
    test_jal();
    test_branch();
    test_saturation();
    test_read_before_write();
    test_rdy_hold();
    test_jalr_miss();
    test_jalr_hit();
    test_flush();
    test_reset_in_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 6; the BHT and BTB each hold 2^INDEX_W entries.
REQ-002 SHALL have parameter CTR_W, default 2; width of each saturating counter.
REQ-003 SHALL have parameter TAG_W, default 8; width of each BTB tag.
REQ-004 SHALL have parameter CTR_INIT, default 1 (weakly not-taken); value of every counter after reset.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous, active-low reset; rdy  in  1  global enable.
REQ-006 SHALL have ports: req_valid in 1 fetched instruction present; req_pc in 32 its address; req_instr in 32 instruction word; req_ready out 1 predictor can accept.
REQ-007 SHALL have ports: resp_valid out 1; resp_is_jump out 1; resp_taken out 1; resp_pc out 32 predicted next PC.
REQ-008 SHALL have ports: upd_valid in 1 ROB commit of a jump; upd_pc in 32; upd_is_jalr in 1; upd_taken in 1; upd_target in 32.
REQ-009 SHALL have ports: alu_jalr_valid in 1 ALU broadcast of a resolved JALR; alu_jalr_target in 32; flush in 1 ROB mispredict clear.

Function
REQ-010 SHALL gate all state changes with rdy; when rdy=0, every register holds its value.
REQ-011 SHALL compute idx = pc[INDEX_W+1:2] and tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
REQ-012 SHALL accept a request when req_valid and req_ready are both 1, and produce the response exactly one cycle later with resp_valid=1 for that one cycle.
REQ-013 SHALL decode JAL (opcode 1101111) as is_jump=1, taken=1, pc = req_pc + sign-extended J-immediate.
REQ-014 SHALL decode a branch (opcode 1100011) as is_jump=1, taken = counter MSB, pc = taken ? req_pc + sign-extended B-immediate : req_pc+4.
REQ-015 SHALL decode JALR (opcode 1100111) on a BTB hit (valid entry with matching tag) as is_jump=1, taken=1, pc = stored target.
REQ-016 SHALL, on a JALR BTB miss, emit no response, enter state WAIT_JALR and drive req_ready=0.
REQ-017 SHALL decode any other opcode as is_jump=0, taken=0, pc = req_pc+4.
REQ-018 SHALL run a two-state FSM: IDLE (req_ready=1) and WAIT_JALR (req_ready=0).
REQ-019 SHALL, in WAIT_JALR with alu_jalr_valid=1, respond next cycle with is_jump=1, taken=1, pc = alu_jalr_target, and return to IDLE.
REQ-020 SHALL give flush priority over all else: return to IDLE, clear resp_valid next cycle, discard any in-flight response; table contents are kept.
REQ-021 SHALL, on upd_valid with upd_is_jalr=0, increment counter[idx] if upd_taken and decrement it otherwise, saturating at 0 and 2^CTR_W-1.
REQ-022 SHALL, on upd_valid with upd_is_jalr=1, write BTB[idx] with valid=1, tag and upd_target.
REQ-023 SHALL, when a lookup and an update hit the same index in one cycle, return the pre-update value to the lookup.
REQ-024 SHALL ignore alu_jalr_valid while in IDLE.
REQ-025 SHALL compute all address arithmetic modulo 2^32.

Reset
REQ-026 SHALL, when rst=0 at a clk edge, set state=IDLE, resp_valid=0, resp_is_jump=0, resp_taken=0, resp_pc=0, every counter=CTR_INIT and every BTB valid bit=0.
REQ-027 SHALL apply reset over rdy and over any operation in progress, including WAIT_JALR.

Structure
REQ-028 SHALL place the opcode constants (JAL, JALR, BRANCH), the FSM state encodings and the default parameter values in the shared define file.
REQ-029 SHALL implement the counter table as one sub-module, sat_counter_table: parametrised, one read port, one update port, read-before-write.
REQ-030 SHALL keep the BTB and the immediate decode inline.

Verification
REQ-031 Reset then JAL at 0x100 with offset +0x20 -> next cycle resp_valid=1, is_jump=1, taken=1, resp_pc=0x120.
REQ-032 Branch at 0x200 with offset -8, counter=1 -> taken=0, pc=0x204; after two taken updates (counter=3) -> taken=1, pc=0x1F8.
REQ-033 Four not-taken updates from counter=1 -> counter stays 0; four taken updates -> counter stays 3; no wrap-around.
REQ-034 JALR at 0x300 with BTB empty -> req_ready=0; alu_jalr_valid with target 0x480 -> next cycle resp_pc=0x480, req_ready=1.
REQ-035 ROB JALR update for pc 0x300 with target 0x480, then JALR fetched again -> one-cycle response with pc=0x480 and no stall.
REQ-036 rst=0 asserted during WAIT_JALR, or flush asserted together with alu_jalr_valid -> next cycle state=IDLE, resp_valid=0.
